// File: rtl/reg_bus_regfile_pkg.sv
// Shared definitions for the reg_bus_regfile responder: register map,
// control/status bit positions and the bus access decode helper.
package reg_bus_regfile_pkg;

    localparam int unsigned ADDR_ID       = 0;
    localparam int unsigned ADDR_SCRATCH  = 1;
    localparam int unsigned ADDR_CTRL     = 2;
    localparam int unsigned ADDR_STATUS   = 3;
    localparam int unsigned ADDR_IRQ_EN   = 4;
    localparam int unsigned ADDR_TMR_LOAD = 5;
    localparam int unsigned ADDR_TMR_CNT  = 6;

    localparam int unsigned CTRL_TMR_EN = 0;
    localparam int unsigned STS_TMR     = 0;

    typedef enum logic [1:0] {
        ACC_IDLE  = 2'd0,
        ACC_READ  = 2'd1,
        ACC_WRITE = 2'd2
    } acc_e;

    function automatic acc_e decode_acc(input logic req, input logic wr);
        if (!req) return ACC_IDLE;
        return wr ? ACC_WRITE : ACC_READ;
    endfunction

endpackage

// File: rtl/reg_bus_timer.sv
// Reload down-counter: counts to zero, pulses expire and reloads from load.
// A write to the load register also restarts the count and masks expiry.
module reg_bus_timer #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          load_we,
    input  logic [DW-1:0] load_wdata,
    output logic [DW-1:0] load,
    output logic [DW-1:0] cnt,
    output logic          expire
);

    logic [DW-1:0] cnt_next;

    always_comb begin
        cnt_next = cnt;
        expire   = 1'b0;
        if (load_we) begin
            cnt_next = load_wdata;
        end else if (en) begin
            if (cnt == '0) begin
                cnt_next = load;
                expire   = 1'b1;
            end else begin
                cnt_next = cnt - DW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            load <= '0;
            cnt  <= '0;
        end else begin
            if (load_we) begin
                load <= load_wdata;
            end
            cnt <= cnt_next;
        end
    end

endmodule

// File: rtl/reg_bus_regfile.sv
// Register-bus responder serving ID, scratch, control, W1C status,
// interrupt enable and a reload timer, with a registered interrupt output.
module reg_bus_regfile
    import reg_bus_regfile_pkg::*;
#(
    parameter int          REG_AW   = 8,
    parameter int          REG_DW   = 8,
    parameter logic [7:0]  ID_VALUE = 8'hA5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              reg_req,
    input  logic              reg_wr,
    input  logic [REG_AW-1:0] reg_addr,
    input  logic [REG_DW-1:0] reg_wdata,
    output logic [REG_DW-1:0] reg_rdata,
    input  logic [REG_DW-2:0] hw_evt,
    output logic              irq
);

    // Handshake: reg_req qualifies reg_wr/reg_addr/reg_wdata at each rising
    // edge. There is no ready, so every request completes at that edge; read
    // data lands in reg_rdata after it and holds until the next read.

    localparam logic [REG_DW-1:0] ID_WORD = REG_DW'(ID_VALUE);

    function automatic logic addr_is(input logic [REG_AW-1:0] a, input int unsigned idx);
        return a == REG_AW'(idx);
    endfunction

    acc_e acc;
    logic is_wr;
    logic is_rd;

    assign acc   = decode_acc(reg_req, reg_wr);
    assign is_wr = (acc == ACC_WRITE);
    assign is_rd = (acc == ACC_READ);

    logic hit_id, hit_scratch, hit_ctrl, hit_status, hit_irq_en, hit_tmr_load, hit_tmr_cnt;

    assign hit_id       = addr_is(reg_addr, ADDR_ID);
    assign hit_scratch  = addr_is(reg_addr, ADDR_SCRATCH);
    assign hit_ctrl     = addr_is(reg_addr, ADDR_CTRL);
    assign hit_status   = addr_is(reg_addr, ADDR_STATUS);
    assign hit_irq_en   = addr_is(reg_addr, ADDR_IRQ_EN);
    assign hit_tmr_load = addr_is(reg_addr, ADDR_TMR_LOAD);
    assign hit_tmr_cnt  = addr_is(reg_addr, ADDR_TMR_CNT);

    logic [REG_DW-1:0] scratch;
    logic [REG_DW-1:0] ctrl;
    logic [REG_DW-1:0] status;
    logic [REG_DW-1:0] irq_en;
    logic [REG_DW-2:0] evt_prev;

    logic [REG_DW-1:0] tmr_load;
    logic [REG_DW-1:0] tmr_cnt;
    logic              tmr_expire;
    logic              tmr_en;

    assign tmr_en = ctrl[CTRL_TMR_EN];

    reg_bus_timer #(
        .DW (REG_DW)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .en         (tmr_en),
        .load_we    (is_wr && hit_tmr_load),
        .load_wdata (reg_wdata),
        .load       (tmr_load),
        .cnt        (tmr_cnt),
        .expire     (tmr_expire)
    );

    logic [REG_DW-2:0] evt_rise;
    logic [REG_DW-1:0] status_set;
    logic [REG_DW-1:0] status_clr;
    logic [REG_DW-1:0] status_next;
    logic [REG_DW-1:0] irq_en_next;

    assign evt_rise = hw_evt & ~evt_prev;

    // Sets are OR-ed in after the clear so a same-edge set always wins.
    always_comb begin
        status_set               = '0;
        status_set[REG_DW-1:1]   = evt_rise;
        status_set[STS_TMR]      = tmr_expire;
        status_clr               = (is_wr && hit_status) ? reg_wdata : '0;
        status_next              = (status & ~status_clr) | status_set;
        irq_en_next              = (is_wr && hit_irq_en) ? reg_wdata : irq_en;
    end

    logic [REG_DW-1:0] rd_mux;

    always_comb begin
        rd_mux = '0;
        if (hit_id)            rd_mux = ID_WORD;
        else if (hit_scratch)  rd_mux = scratch;
        else if (hit_ctrl)     rd_mux = ctrl;
        else if (hit_status)   rd_mux = status;
        else if (hit_irq_en)   rd_mux = irq_en;
        else if (hit_tmr_load) rd_mux = tmr_load;
        else if (hit_tmr_cnt)  rd_mux = tmr_cnt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scratch   <= '0;
            ctrl      <= '0;
            status    <= '0;
            irq_en    <= '0;
            evt_prev  <= '0;
            reg_rdata <= '0;
            irq       <= 1'b0;
        end else begin
            if (is_wr && hit_scratch) begin
                scratch <= reg_wdata;
            end
            if (is_wr && hit_ctrl) begin
                ctrl <= reg_wdata;
            end
            if (is_rd) begin
                reg_rdata <= rd_mux;
            end
            status   <= status_next;
            irq_en   <= irq_en_next;
            evt_prev <= hw_evt;
            irq      <= |(status_next & irq_en_next);
        end
    end

endmodule
